// File: rtl/seg7_pkg.sv
// Shared types and constants for the time-shared seven-segment display scheduler.
// The SEM byte is {dp, a, b, c, d, e, f, g}, active-low.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

  // Converter segment a sits in bit 0 but drives SEM bit 6, so the bits are reversed and inverted.
  function automatic logic [7:0] seg_encode(input logic [6:0] seg7, input logic dp);
    logic [7:0] enc;
    enc[7] = ~dp;
    for (int k = 0; k < 7; k++) begin
      enc[6-k] = ~seg7[k];
    end
    return enc;
  endfunction

endpackage

// File: rtl/seg7_blink_timer.sv
// Free-running blink phase generator.
// The phase toggles every BLINK_DIV cycles while enabled and is held clear otherwise.
module seg7_blink_timer #(
  parameter int unsigned BLINK_DIV = 5_000_000
) (
  input  logic CLOCK_10,
  input  logic RESET_N,
  input  logic blink_en,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  always_ff @(posedge CLOCK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!blink_en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/seg7_display_sched.sv
// Walks a captured 16-bit hex value through one shared converter, one nibble per cycle,
// then commits all four digits at once with leading-zero blanking and blink applied.
module seg7_display_sched
  import seg7_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 5_000_000
) (
  input  logic            CLOCK_10,
  input  logic            RESET_N,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [15:0]     ld_value,
  input  logic [3:0]      ld_dp,
  input  logic            ld_lzb,
  input  logic            blink_en,
  output logic [3:0]      conv_nibble,
  input  logic [6:0]      conv_seg,
  output logic            busy,
  output logic [3:0][7:0] SEM
);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_nx;
  logic [15:0]     value_q;
  logic [3:0]      dp_q;
  logic            lzb_q;
  logic [3:0]      nibble_q;
  logic [3:0][7:0] shadow_q, sem_q, commit_sem;
  logic [3:0]      lead_zero;
  logic            phase;

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) state_d = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (idx_q == 2'd3) state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_nx = idx_q + 2'd1;

  // A digit blanks only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lead_zero[3] = (value_q[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] & (value_q[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] & (value_q[7:4] == 4'h0);
    lead_zero[0] = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      commit_sem[i] = (lzb_q && lead_zero[i]) ? SEG_BLANK : shadow_q[i];
    end
  end

  always_ff @(posedge CLOCK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      value_q  <= '0;
      dp_q     <= '0;
      lzb_q    <= 1'b0;
      nibble_q <= '0;
      shadow_q <= '0;
      sem_q    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ld_valid) begin
        value_q  <= ld_value;
        dp_q     <= ld_dp;
        lzb_q    <= ld_lzb;
        idx_q    <= 2'd0;
        nibble_q <= ld_value[3:0];
      end
      if (state_q == CONV) begin
        shadow_q[idx_q] <= seg_encode(conv_seg, dp_q[idx_q]);
        idx_q           <= idx_nx;
        if (idx_q != 2'd3) nibble_q <= value_q[{idx_nx, 2'b00} +: 4];
      end
      if (state_q == COMMIT) sem_q <= commit_sem;
    end
  end

  seg7_blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .CLOCK_10(CLOCK_10),
    .RESET_N (RESET_N),
    .blink_en(blink_en),
    .phase   (phase)
  );

  assign conv_nibble = nibble_q;
  assign SEM         = sem_q | {(NUM_DIGITS * 8){blink_en & phase}};

endmodule

// File: tb/tb_seg7_display_sched.sv
// Directed bench for seg7_display_sched with a hex-table model of the external converter.
module tb_seg7_display_sched;

  logic            CLOCK_10 = 1'b0;
  logic            RESET_N;
  logic            ld_valid;
  logic            ld_ready;
  logic [15:0]     ld_value;
  logic [3:0]      ld_dp;
  logic            ld_lzb;
  logic            blink_en;
  logic [3:0]      conv_nibble;
  logic [6:0]      conv_seg;
  logic            busy;
  logic [3:0][7:0] SEM;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_10 = ~CLOCK_10;

  seg7_display_sched #(
    .BLINK_DIV(4)
  ) dut (
    .CLOCK_10   (CLOCK_10),
    .RESET_N    (RESET_N),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_value   (ld_value),
    .ld_dp      (ld_dp),
    .ld_lzb     (ld_lzb),
    .blink_en   (blink_en),
    .conv_nibble(conv_nibble),
    .conv_seg   (conv_seg),
    .busy       (busy),
    .SEM        (SEM)
  );

  // Active-high a..g in bits 0..6.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F;  4'h1: hex_seg = 7'h06;  4'h2: hex_seg = 7'h5B;  4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;  4'h5: hex_seg = 7'h6D;  4'h6: hex_seg = 7'h7D;  4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h6F;  4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;  4'hD: hex_seg = 7'h5E;  4'hE: hex_seg = 7'h79;  default: hex_seg = 7'h71;
    endcase
  endfunction

  assign conv_seg = hex_seg(conv_nibble);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_10);
    #1;
  endtask

  // Drives one load from IDLE and checks nibble walk, busy, no early SEM change and final SEM.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z,
                         input logic [31:0] prev_sem, input logic [31:0] exp_sem);
    ld_value = v;
    ld_dp    = d;
    ld_lzb   = z;
    ld_valid = 1'b1;
    check("ready_idle", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("conv_nibble", 32'(conv_nibble), 32'(v[4*i +: 4]));
      check("busy_conv", 32'(busy), 32'd1);
      check("sem_hold", SEM, prev_sem);
      step();
    end
    check("busy_commit", 32'(busy), 32'd1);
    check("ready_commit", 32'(ld_ready), 32'd0);
    check("sem_hold_commit", SEM, prev_sem);
    step();
    check("sem_commit", SEM, exp_sem);
    check("busy_done", 32'(busy), 32'd0);
    check("ready_done", 32'(ld_ready), 32'd1);
  endtask

  initial begin
    RESET_N  = 1'b0;
    ld_valid = 1'b0;
    ld_value = '0;
    ld_dp    = '0;
    ld_lzb   = 1'b0;
    blink_en = 1'b0;
    #12;
    check("rst_sem", SEM, 32'hFFFF_FFFF);
    check("rst_ready", 32'(ld_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nibble", 32'(conv_nibble), 32'd0);
    step();
    RESET_N = 1'b1;
    step();

    do_load(16'h1234, 4'b0000, 1'b0, 32'hFFFF_FFFF, 32'hCF92_86CC);
    do_load(16'h00A0, 4'b1000, 1'b1, 32'hCF92_86CC, 32'hFFFF_8881);
    do_load(16'h0000, 4'b0000, 1'b1, 32'hFFFF_8881, 32'hFFFF_FF81);
    do_load(16'h00A0, 4'b1000, 1'b0, 32'hFFFF_FF81, 32'h0181_8881);
    do_load(16'h8888, 4'b1111, 1'b0, 32'h0181_8881, 32'h0000_0000);
    do_load(16'h00A0, 4'b1000, 1'b0, 32'h0000_0000, 32'h0181_8881);

    // Held request: second value must wait for the first commit.
    ld_value = 16'hBEEF;
    ld_dp    = 4'b0000;
    ld_lzb   = 1'b0;
    ld_valid = 1'b1;
    step();
    ld_value = 16'h1111;
    check("hold_first_nibble", 32'(conv_nibble), 32'hF);
    for (int i = 0; i < 5; i++) begin
      check("hold_ready_low", 32'(ld_ready), 32'd0);
      check("hold_sem_old", SEM, 32'h0181_8881);
      step();
    end
    check("hold_sem_beef", SEM, 32'hE0B0_B0B8);
    check("hold_ready_high", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    check("hold_second_nibble", 32'(conv_nibble), 32'h1);
    check("hold_second_busy", 32'(busy), 32'd1);
    check("hold_sem_keep", SEM, 32'hE0B0_B0B8);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_no_tear", SEM, 32'hE0B0_B0B8);
    end
    step();
    check("hold_sem_1111", SEM, 32'hCFCF_CFCF);

    // Blink with period 4 cycles per half.
    blink_en = 1'b1;
    step();
    check("blink_on_1", SEM, 32'hCFCF_CFCF);
    step();
    step();
    check("blink_on_3", SEM, 32'hCFCF_CFCF);
    step();
    check("blink_off_4", SEM, 32'hFFFF_FFFF);
    step();
    step();
    step();
    check("blink_off_7", SEM, 32'hFFFF_FFFF);
    step();
    check("blink_on_8", SEM, 32'hCFCF_CFCF);
    for (int i = 0; i < 4; i++) step();
    check("blink_off_12", SEM, 32'hFFFF_FFFF);
    step();
    blink_en = 1'b0;
    step();
    check("blink_restore", SEM, 32'hCFCF_CFCF);
    for (int i = 0; i < 4; i++) step();
    check("blink_stay_on", SEM, 32'hCFCF_CFCF);

    // Reset during conversion abandons the load.
    ld_value = 16'hFFFF;
    ld_dp    = 4'b0000;
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    step();
    step();
    check("mid_idx2_nibble", 32'(conv_nibble), 32'hF);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_sem", SEM, 32'hFFFF_FFFF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(ld_ready), 32'd1);
    #2;
    RESET_N = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("post_rst_blank", SEM, 32'hFFFF_FFFF);
    end
    check("post_rst_busy", 32'(busy), 32'd0);

    do_load(16'h1234, 4'b0000, 1'b0, 32'hFFFF_FFFF, 32'hCF92_86CC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
